// File: rtl/inv_cipher_seq_if.sv
// Block-port bundle for inv_cipher_seq: key load strobe, ciphertext in and plaintext out.
// The source of key/ciphertext and the sink of plaintext use master; the decryptor uses slave.
interface inv_cipher_seq_if #(parameter int NK = 4);
  logic              key_load;
  logic [32*NK-1:0]  key;
  logic              key_ready;
  logic              in_vld;
  logic              in_rdy;
  logic [127:0]      in_dat;
  logic              out_vld;
  logic              out_rdy;
  logic [127:0]      out_dat;

  modport master (
    output key_load, key, in_vld, in_dat, out_rdy,
    input  key_ready, in_rdy, out_vld, out_dat
  );

  modport slave (
    input  key_load, key, in_vld, in_dat, out_rdy,
    output key_ready, in_rdy, out_vld, out_dat
  );
endinterface

// File: rtl/inv_cipher_seq.sv
// Iterative AES inverse cipher: expands the key one word per clock, then decrypts one round per clock.
// out_vld rises Nr+1 cycles after acceptance and holds until out_rdy; in_rdy stays low while busy.
module inv_cipher_seq #(parameter int NK = 4) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  inv_cipher_seq_if.slave io_bus
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t       r_state;
  logic         r_key_ready;
  logic         r_out_vld;
  logic [127:0] r_blk;
  logic [3:0]   r_rnd;
  logic [5:0]   r_idx;
  logic [2:0]   r_kcnt;
  logic [7:0]   r_rcon;
  logic [31:0]  r_w [NW];

  logic         w_in_rdy;
  logic         w_key_start;
  logic [3:0]   w_rk_sel;
  logic [127:0] w_rk;
  logic [127:0] w_srsb;
  logic [127:0] w_next_blk;
  logic [31:0]  w_prev;
  logic [31:0]  w_old;
  logic [31:0]  w_temp;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, v;
    p = 8'h00;
    v = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ v;
      v = xt(v);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t;
    t = gmul(gmul(a, a), a);
    for (int i = 0; i < 5; i++) t = gmul(gmul(t, t), a);
    return gmul(t, t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k = row + 4*col sits at bits [127-8k -: 8]; row r rotates right by r columns
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = isbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [7:0]   a [4];
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                             ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

  assign w_in_rdy    = r_key_ready && (r_state == IDLE) && !io_bus.key_load;
  assign w_key_start = (r_state == IDLE) && io_bus.key_load;

  always_comb begin
    w_rk_sel   = (r_state == ROUND) ? r_rnd : 4'(NR);
    w_rk       = {r_w[{w_rk_sel, 2'd0}], r_w[{w_rk_sel, 2'd1}],
                  r_w[{w_rk_sel, 2'd2}], r_w[{w_rk_sel, 2'd3}]};
    w_srsb     = inv_sr_sb(r_blk);
    w_next_blk = (r_rnd != 4'd0) ? inv_mix(w_srsb ^ w_rk) : (w_srsb ^ w_rk);
    w_prev     = r_w[r_idx - 6'd1];
    w_old      = r_w[r_idx - 6'(NK)];
    if (r_kcnt == 3'd0)
      w_temp = subw({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_kcnt == 3'd4)
      w_temp = subw(w_prev);
    else
      w_temp = w_prev;
  end

  // Round-key store has no reset; key_ready guards its contents
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_key_start) begin
      for (int k = 0; k < NK; k++) r_w[k] <= io_bus.key[32*NK-1-32*k -: 32];
    end else if (i_rst_n && r_state == KEYEXP) begin
      r_w[r_idx] <= w_old ^ w_temp;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_key_ready <= 1'b0;
      r_out_vld   <= 1'b0;
      r_blk       <= '0;
      r_rnd       <= '0;
      r_idx       <= '0;
      r_kcnt      <= '0;
      r_rcon      <= 8'h01;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.key_load) begin
            r_key_ready <= 1'b0;
            r_idx       <= 6'(NK);
            r_kcnt      <= '0;
            r_rcon      <= 8'h01;
            r_state     <= KEYEXP;
          end else if (io_bus.in_vld && w_in_rdy) begin
            r_blk   <= io_bus.in_dat ^ w_rk;
            r_rnd   <= 4'(NR - 1);
            r_state <= ROUND;
          end
        end
        KEYEXP: begin
          r_idx  <= r_idx + 6'd1;
          r_kcnt <= (r_kcnt == 3'(NK - 1)) ? 3'd0 : r_kcnt + 3'd1;
          if (r_kcnt == 3'd0) r_rcon <= xt(r_rcon);
          if (r_idx == 6'(NW - 1)) begin
            r_key_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        ROUND: begin
          r_blk <= w_next_blk;
          if (r_rnd == 4'd0) r_state <= DONE;
          else               r_rnd   <= r_rnd - 4'd1;
        end
        DONE: begin
          // out_vld follows DONE by one clock; the result then waits for the consumer
          if (r_out_vld && io_bus.out_rdy) begin
            r_out_vld <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_out_vld <= 1'b1;
          end
        end
      endcase
    end
  end

  assign io_bus.key_ready = r_key_ready;
  assign io_bus.in_rdy    = w_in_rdy;
  assign io_bus.out_vld   = r_out_vld;
  assign io_bus.out_dat   = r_blk;
endmodule

// File: tb/tb_inv_cipher_seq.sv
// Bench for inv_cipher_seq: FIPS vectors plus random blocks encrypted by a forward-cipher model.
module tb_inv_cipher_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_cipher_seq_if #(.NK(4)) bus();
  inv_cipher_seq_if #(.NK(8)) bus8();
  inv_cipher_seq #(.NK(4)) dut  (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));
  inv_cipher_seq #(.NK(8)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus8));

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb [256];
  logic [31:0]  mw [60];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares on each output handshake
  always begin
    @(negedge clk);
    #1;
    if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got %h, need no output", bus.out_dat);
      end else begin
        chk("out_dat", bus.out_dat, exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Walks powers of 3 and 3^-1 in lockstep to fill the forward S-box
  task automatic init_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ m2(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [7:0]  rc;
    logic [31:0] t;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) mw[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = mw[i-1];
      if (i % 4 == 0) begin
        t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m2(rc);
      end
      mw[i] = mw[i-4] ^ t;
    end
  endtask

  function automatic logic [7:0] rkb(input int r, input int k);
    logic [31:0] w;
    w = mw[4*r + k/4];
    return w[31-8*(k%4) -: 8];
  endfunction

  // Forward AES-128 of the model key; the DUT must invert it
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rkb(0, k);
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (r != 10) begin
          s[4*c]   = m2(t[4*c]) ^ m2(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ m2(t[4*c+1]) ^ m2(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ m2(t[4*c+2]) ^ m2(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = m2(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ m2(t[4*c+3]);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rkb(r, k);
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_key(input int want);
    int n = 0;
    while (bus.key_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("keyexp_lat", n, want);
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.key = k;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    chk("key_ready_clr", bus.key_ready, 0);
    wait_key(40);
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    int n = 0;
    bus.in_dat = ct;
    bus.in_vld = 1'b1;
    while (bus.in_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: in_rdy stayed 0, need 1");
    end else begin
      exp_q.push_back(pt);
      acc_cyc = cyc;
    end
    @(negedge clk);
    bus.in_vld = 1'b0;
  endtask

  task automatic out_lat(input int want);
    int n = 0;
    while (bus.out_vld !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_lat", n, want);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time expired, need completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] key, pt, pt2, hold;
    int n, prev, bad;
    init_sbox();
    bus.key_load = 0; bus.key = '0; bus.in_vld = 0; bus.in_dat = '0; bus.out_rdy = 0;
    bus8.key_load = 0; bus8.key = '0; bus8.in_vld = 0; bus8.in_dat = '0; bus8.out_rdy = 1;
    repeat (3) @(negedge clk);
    chk("rst_key_ready", bus.key_ready, 0);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_dat", bus.out_dat, 0);
    rst_n = 1'b1;

    // AES-256 vector on the Nk=8 instance
    bus8.key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    bus8.key_load = 1'b1;
    @(negedge clk);
    bus8.key_load = 1'b0;
    n = 0;
    while (bus8.key_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("keyexp_lat_256", n, 52);
    bus8.in_dat = 128'h8ea2b7ca516745bfeafc49904b496089;
    bus8.in_vld = 1'b1;
    chk("in_rdy_256", bus8.in_rdy, 1);
    @(negedge clk);
    bus8.in_vld = 1'b0;
    n = 0;
    while (bus8.out_vld !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("out_lat_256", n, 15);
    chk("aes256_out", bus8.out_dat, 128'h00112233445566778899aabbccddeeff);

    bus.out_rdy = 1'b1;
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    send(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734);
    out_lat(11);
    drain();
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
    out_lat(11);
    drain();

    // Random keys: back-to-back throughput, then random consumer stalls
    for (int kk = 0; kk < 2; kk++) begin
      key = rnd128();
      expand(key);
      load_key(key);
      prev = 0;
      for (int b = 0; b < 4; b++) begin
        pt = rnd128();
        send(encrypt(pt), pt);
        if (b > 0) chk("throughput", acc_cyc - prev, 13);
        prev = acc_cyc;
      end
      drain();
      for (int b = 0; b < 4; b++) begin
        pt = rnd128();
        send(encrypt(pt), pt);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
          @(negedge clk);
          bus.out_rdy = 1'($urandom_range(0, 1));
          n++;
        end
        bus.out_rdy = 1'b1;
        drain();
      end
    end

    // Backpressure with a second block waiting
    pt = rnd128();
    pt2 = rnd128();
    bus.out_rdy = 1'b0;
    send(encrypt(pt), pt);
    out_lat(11);
    bus.in_dat = encrypt(pt2);
    bus.in_vld = 1'b1;
    hold = bus.out_dat;
    chk("bp_first", hold, pt);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_dat !== hold || bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b1) bad++;
    end
    chk("bp_hold", bad, 0);
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    chk("bp_in_rdy", bus.in_rdy, 1);
    exp_q.push_back(pt2);
    @(negedge clk);
    bus.in_vld = 1'b0;
    out_lat(11);
    bus.out_rdy = 1'b1;
    drain();

    // key_load during ROUND is ignored
    pt = rnd128();
    send(encrypt(pt), pt);
    @(negedge clk);
    bus.key = ~key;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    drain();
    chk("kl_round_ready", bus.key_ready, 1);
    pt2 = rnd128();
    send(encrypt(pt2), pt2);
    drain();

    // key_load beats in_vld in the same IDLE cycle
    n = 0;
    while (bus.in_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    key = rnd128();
    expand(key);
    bus.key = key;
    bus.key_load = 1'b1;
    bus.in_vld = 1'b1;
    bus.in_dat = rnd128();
    #1;
    chk("prio_in_rdy", bus.in_rdy, 0);
    @(negedge clk);
    bus.key_load = 1'b0;
    bus.in_vld = 1'b0;
    chk("prio_keyexp", bus.key_ready, 0);
    wait_key(40);
    pt = rnd128();
    send(encrypt(pt), pt);
    drain();

    // Reset during round 5
    n = 0;
    while (bus.in_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.in_dat = encrypt(rnd128());
    bus.in_vld = 1'b1;
    @(negedge clk);
    bus.in_vld = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_out_vld", bus.out_vld, 0);
    chk("rst_mid_key_ready", bus.key_ready, 0);
    chk("rst_mid_in_rdy", bus.in_rdy, 0);
    bus.in_vld = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.in_rdy !== 1'b0) bad++;
    end
    bus.in_vld = 1'b0;
    chk("rst_no_accept", bad, 0);
    load_key(key);
    pt = rnd128();
    send(encrypt(pt), pt);
    out_lat(11);
    drain();

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/inv_cipher_seq.md
# inv_cipher_seq

Iterative AES inverse cipher (FIPS-197 §5.3) that undoes the combinational `cipher` block. It expands a loaded key into an internal round-key register file, one word per cycle. It then decrypts one 128-bit block per transaction at one round per clock. It is the receive-side counterpart of the encrypt path and uses valid/ready handshakes on both block ports.

## Interface
- Nb, 4, columns per state (fixed at 4).
- Nk, 4, key length in 32-bit words: 4, 6 or 8.
- Nr, 10, number of rounds; must equal Nk+6.
- clk  in  1  single clock; all logic rises on posedge.
- rst_n  in  1  reset; synchronous and active-low.
- key_load  in  1  one-cycle strobe; captures Key and starts key expansion.
- Key  in  32*Nk  cipher key; Key[32*Nk-1 -: 32] is w[0].
- key_ready  out  1  round keys are valid.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in  in  128  ciphertext; in[127:120] is state byte 0 (column-major, FIPS order).
- out_valid  out  1  plaintext available; held until out_ready.
- out_ready  in  1  consumer accepts out.
- out  out  128  plaintext, same byte order as in.

## Operation
- Round-key store holds 4*(Nr+1) words w[0..4Nr+3]. Round key r is w[4r..4r+3], packed w[4r] in bits [127:96].
- FSM states:
  - IDLE → KEYEXP on key_load.
  - IDLE → ROUND on an input handshake.
  - KEYEXP → IDLE when the last word is written.
  - ROUND → DONE after round 0.
  - DONE → IDLE on out_valid && out_ready.
- KEYEXP:
  - w[0..Nk-1] ← Key on the key_load edge. key_ready clears on that same edge.
  - Then one word per cycle: w[i] = w[i-Nk] ^ temp.
  - temp = SubWord(RotWord(w[i-1]))^Rcon[i/Nk] when i%Nk==0.
  - temp = SubWord(w[i-1]) when Nk==8 and i%Nk==4.
  - Otherwise temp = w[i-1].
  - key_ready sets on the edge that writes w[4Nr+3].
- in_ready = key_ready && state==IDLE && !key_load.
- Input handshake:
  - state ← in ^ rk[Nr].
  - round counter ← Nr-1.
- ROUND, counter r > 0:
  - state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])).
- ROUND, r == 0:
  - state ← InvSubBytes(InvShiftRows(state)) ^ rk[0].
  - Go to DONE.
- DONE: out_valid=1 and out = state register; both held stable until out_ready.
- key_load is honoured only in IDLE; it is ignored in KEYEXP, ROUND and DONE.
- key_load and in_valid together in IDLE: key_load wins and the block is not accepted (in_ready=0).
- in_valid without key_ready is never accepted.
- Inverse S-box is combinational logic or a case ROM. Forward S-box is needed only for key expansion. All GF(2^8) arithmetic uses polynomial 0x11B.

## Timing
- Reset values (rst_n low at a clk edge):
  - state = IDLE
  - key_ready = 0
  - in_ready = 0
  - out_valid = 0
  - out = 0
  - round counter = 0
  - round-key store not cleared
- Reset mid-operation aborts KEYEXP or ROUND immediately. A key must be reloaded before any further block is accepted.
- Key expansion, key_load sampled at edge E: key_ready is high after edge E+4(Nr+1)-Nk. That is E+40 for AES-128, E+46 for AES-192, E+52 for AES-256.
- Block latency, handshake at edge T:
  - out_valid is high after edge T+Nr+1 (T+11 for AES-128).
  - The one-cycle-per-round cadence is mandatory.
- Output handshake at edge D: out_valid low and in_ready high after D. The earliest next acceptance is edge D+1.
- Throughput: one block per Nr+3 cycles when out_ready is held high.
- out_ready is ignored when out_valid=0.

## Test plan
- AES-128 (FIPS-197 App. B):
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Response: out 3243f6a8885a308d313198a2e0370734. key_ready 40 cycles after key_load; out_valid 11 cycles after acceptance.
- AES-128 C.1:
  - Stimulus: key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out 00112233445566778899aabbccddeeff.
- AES-256 (Nk=8, Nr=14) C.3:
  - Stimulus: key 000102…1f, ct 8ea2b7ca516745bfeafc49904b496089.
  - Response: out 00112233445566778899aabbccddeeff. key_ready after 52 cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid; hold in_valid=1 with a second block.
  - Response: out stable, in_ready=0 throughout. After the out_ready pulse, the second block is accepted next cycle and decrypts correctly.
- Ignored and priority events:
  - key_load pulsed during ROUND → current result unchanged and key_ready stays 1.
  - key_load and in_valid in the same IDLE cycle → no block accepted; KEYEXP entered.
- Reset mid-round:
  - Stimulus: rst_n=0 at round 5.
  - Response: out_valid=0, key_ready=0, in_ready=0 next cycle. Block not accepted until the key is reloaded; then a correct decrypt follows.
